decoder_n_low_scan: RTL
=======================

// Module: decoder_n_low_scan
// PURPOSE
//  Parametrised N-to-2^N one-cold (active-low) decoder with a registered output.
//  DIRECT mode: decodes an index accepted on a valid/ready handshake.
//  SCAN mode: free-running cycler that steps the active-low select 0..LAST, dwelling DWELL clocks per index.
//  Drives digit/row selects (multiplexed 7-seg, keypad columns) downstream of control logic.
// PARAMETERS
//  N      2          index width; output width 2^N
//  LAST   2**N-1     highest legal/scanned index (0 < LAST <= 2^N-1)
//  DWELL  4          clocks each index stays active in SCAN (>=1)
// PORTS
//  clk       in   1     clock, rising edge
//  rst       in   1     synchronous, active-high reset
//  en        in   1     1 = operate; 0 = blank outputs, hold position
//  mode      in   1     0 = DIRECT, 1 = SCAN
//  in_valid  in   1     DIRECT: w is valid
//  in_ready  out  1     DIRECT: block accepts w this cycle
//  w         in   N     DIRECT: index to decode
//  y         out  2^N   one-cold select, active low (all-ones = none selected)
//  sel       out  N     index currently driven on y
//  err       out  1     one-cycle pulse: accepted w > LAST
//  wrap      out  1     one-cycle pulse: SCAN stepped LAST -> 0
// BEHAVIOUR
//  Reset (rst=1 at an edge): y='1, sel=0, err=0, wrap=0, dwell counter=0, state=BLANK. in_ready is low while rst=1.
//  Priority: rst > en=0 > mode change > normal operation.
//  States: BLANK, DIRECT, SCAN, GAP (GAP exists only with the macro).
//  BLANK: y='1. Leaves on the first edge with en=1, entering DIRECT or SCAN per mode.
//  en=0 from any state: next edge y='1, state=BLANK; sel and dwell counter hold.
//  in_ready = en & ~mode & ~rst (combinational). A transfer is in_valid & in_ready.
//  DIRECT:
//   - Transfer at edge k: at k+1, y=~(1<<w), sel=w (latency 1).
//   - Without a transfer, y and sel hold.
//   - w>LAST: y='1, sel=w, err=1 for one cycle.
//  SCAN:
//   - Entry (mode 0->1, or from BLANK): sel=0, counter=0, y=~1.
//   - Counter increments every clock. At DWELL-1, next edge: counter=0, sel=(sel==LAST)?0:sel+1, y updated.
//   - wrap=1 on the edge sel goes LAST->0.
//   - in_valid is ignored and in_ready=0.
//  Mode 1->0 while enabled: next edge y='1, state=DIRECT; y stays '1 until the first transfer.
//  Widths: internal counter is clog2(DWELL+1) bits. sel compare is unsigned N bits. y is exactly one-cold or all-ones, never x.
// CONFIGURATION
//  DECN_DEADTIME_EN defined: SCAN inserts one GAP clock (y='1, sel holds) at every step.
//   - Each index is active DWELL clocks, then 1 blank clock; period (LAST+1)*(DWELL+1).
//   - wrap pulses on the edge leaving GAP into sel=0.
//   - DIRECT is unaffected.
//  DECN_DEADTIME_EN undefined: no GAP state; index steps directly; period (LAST+1)*DWELL.
// STRUCTURE
//  decoder_pkg: mode constants (MODE_DIRECT=1'b0, MODE_SCAN=1'b1), state encoding
//   (ST_BLANK, ST_DIRECT, ST_SCAN, ST_GAP), function onecold_low(idx, N).
//  Sub-module decn_dwell_cnt: DWELL-parametrised counter with sync clear/hold and a terminal-count pulse.
//  Top holds the FSM, sel/y registers and the err/wrap pulses.
// TESTING  (N=2, LAST=3, DWELL=4 unless noted)
//  1. rst high 3 clks mid-SCAN -> next edge y=4'b1111, sel=0, wrap=0, err=0; in_ready=0 while rst=1.
//  2. DIRECT, en=1, send w=0,1,2,3 back-to-back -> y=1110,1101,1011,0111 each one clock after its transfer; in_ready stays 1.
//  3. DIRECT, LAST=2, send w=3 -> next clk y=1111, err=1 for exactly 1 clk; then w=1 -> y=1101, err=0.
//  4. SCAN, 20 clks -> y=1110 x4, 1101 x4, 1011 x4, 0111 x4, 1110...; wrap=1 once at clk 16; with DECN_DEADTIME_EN: each index x4, then 1111 x1, wrap at clk 20.
//  5. SCAN at sel=2, drop en 3 clks -> y=1111 and sel=2 held; reassert en -> next edge y=1110, sel=0 (re-entry from BLANK).
//  6. SCAN->DIRECT with in_valid=1, w=2 in the same cycle as mode falls -> in_ready=1; next edge y=1011, sel=2 (transfer wins over blank).

Source files
------------

// File: rtl/decoder_pkg.sv
// Shared constants, FSM state encoding and the one-cold helper for the active-low decoder.
package decoder_pkg;

    localparam logic MODE_DIRECT = 1'b0;
    localparam logic MODE_SCAN   = 1'b1;

    // The helper returns a fixed-width vector; callers keep the low 2^N bits (N <= 6).
    localparam int ONECOLD_MAX = 64;

    typedef enum logic [1:0] {
        ST_BLANK  = 2'd0,
        ST_DIRECT = 2'd1,
        ST_SCAN   = 2'd2,
        ST_GAP    = 2'd3
    } state_t;

    function automatic logic [ONECOLD_MAX-1:0] onecold_low(input int idx, input int n);
        logic [ONECOLD_MAX-1:0] r;
        r = '1;
        for (int i = 0; i < ONECOLD_MAX; i++) begin
            if (i < (1 << n) && i == idx) r[i] = 1'b0;
        end
        return r;
    endfunction

endpackage

// File: rtl/decn_dwell_cnt.sv
// Dwell counter: counts enabled clocks, clears synchronously, flags the last clock of a dwell.
module decn_dwell_cnt #(
    parameter int DWELL = 4,
    parameter int CW    = $clog2(DWELL + 1)
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic inc,
    output logic tc
);

    logic [CW-1:0] count_reg;

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            count_reg <= '0;
        end else if (inc) begin
            count_reg <= count_reg + 1'b1;
        end
    end

    assign tc = (count_reg == CW'(DWELL - 1));

endmodule

// File: rtl/decoder_n_low_scan.sv
// N-to-2^N active-low decoder with DIRECT (handshake) and SCAN (free-running) modes.
// Define DECN_DEADTIME_EN to insert one blank GAP clock between scanned indices.
module decoder_n_low_scan
    import decoder_pkg::*;
#(
    parameter int N     = 2,
    parameter int LAST  = 2**N - 1,
    parameter int DWELL = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                en,
    input  logic                mode,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [N-1:0]        w,
    output logic [(1<<N)-1:0]   y,
    output logic [N-1:0]        sel,
    output logic                err,
    output logic                wrap
);

    localparam int         W        = 1 << N;
    localparam logic [N-1:0] LAST_IDX = N'(LAST);

    state_t         state_reg, state_next;
    logic [W-1:0]   y_reg, y_next;
    logic [N-1:0]   sel_reg, sel_next;
    logic           err_reg, err_next;
    logic           wrap_reg, wrap_next;
    logic           cnt_clr, cnt_inc, cnt_tc;
    logic           xfer;
    logic [N-1:0]   step_sel;
    logic           step_wrap;

    function automatic logic [W-1:0] decode(input logic [N-1:0] idx);
        logic [ONECOLD_MAX-1:0] t;
        t = onecold_low(int'(idx), N);
        return t[W-1:0];
    endfunction

    decn_dwell_cnt #(.DWELL(DWELL)) u_dwell (
        .clk (clk),
        .rst (rst),
        .clr (cnt_clr),
        .inc (cnt_inc),
        .tc  (cnt_tc)
    );

    assign in_ready  = en & ~mode & ~rst;
    assign xfer      = in_valid & in_ready;
    assign step_wrap = (sel_reg == LAST_IDX);
    assign step_sel  = step_wrap ? '0 : sel_reg + 1'b1;

    always_comb begin
        state_next = state_reg;
        y_next     = y_reg;
        sel_next   = sel_reg;
        err_next   = 1'b0;
        wrap_next  = 1'b0;
        cnt_clr    = 1'b0;
        cnt_inc    = 1'b0;

        if (!en) begin
            state_next = ST_BLANK;
            y_next     = '1;
        end else if (mode == MODE_DIRECT) begin
            state_next = ST_DIRECT;
            // Arriving from BLANK/SCAN/GAP blanks the output unless a transfer lands now.
            if (state_reg != ST_DIRECT) y_next = '1;
            if (xfer) begin
                sel_next = w;
                if (w > LAST_IDX) begin
                    y_next   = '1;
                    err_next = 1'b1;
                end else begin
                    y_next = decode(w);
                end
            end
        end else begin
            case (state_reg)
                ST_SCAN: begin
                    if (cnt_tc) begin
                        cnt_clr = 1'b1;
`ifdef DECN_DEADTIME_EN
                        state_next = ST_GAP;
                        y_next     = '1;
`else
                        sel_next  = step_sel;
                        y_next    = decode(step_sel);
                        wrap_next = step_wrap;
`endif
                    end else begin
                        cnt_inc = 1'b1;
                    end
                end
`ifdef DECN_DEADTIME_EN
                ST_GAP: begin
                    state_next = ST_SCAN;
                    sel_next   = step_sel;
                    y_next     = decode(step_sel);
                    wrap_next  = step_wrap;
                end
`endif
                default: begin
                    state_next = ST_SCAN;
                    sel_next   = '0;
                    y_next     = decode('0);
                    cnt_clr    = 1'b1;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= ST_BLANK;
            y_reg     <= '1;
            sel_reg   <= '0;
            err_reg   <= 1'b0;
            wrap_reg  <= 1'b0;
        end else begin
            state_reg <= state_next;
            y_reg     <= y_next;
            sel_reg   <= sel_next;
            err_reg   <= err_next;
            wrap_reg  <= wrap_next;
        end
    end

    assign y    = y_reg;
    assign sel  = sel_reg;
    assign err  = err_reg;
    assign wrap = wrap_reg;

endmodule
